// File: rtl/decoder_2x4_hold.sv
// Purpose : 2-to-4 binary-to-one-hot decoder. Each accepted code is held on b
//           for HOLD_CYCLES clocks and then released.
// Latency : a code accepted at edge N is on b after edge N and stays there
//           through edge N+HOLD_CYCLES.
// Backpressure: a_ready is low while a hold is running and rises on the last
//           hold cycle, so back-to-back codes follow with no gap cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   a_valid  code on a is valid
//   a        2-bit binary code
//   a_ready  combinational: IDLE, or HOLD on its last cycle (hc == 0)
//   b        registered one-hot output
//   b_valid  b currently carries a decoded value
//   done     one-cycle pulse after each hold period ends
//   cnt      accepted-code counter, wraps modulo 2^CNT_W
//
// Build option: define DEC_ACTIVE_LOW_EN for an active-low b (idle 4'b1111).
// The inverted value is stored in the output register itself, so b has no
// combinational stage after the flop.

module decoder_2x4_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [1:0]       a,
  output logic             a_ready,
  output logic [3:0]       b,
  output logic             b_valid,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  // hc only ever holds HOLD_CYCLES-1; keep at least one bit so HOLD_CYCLES=1
  // still elaborates (hc is then stuck at zero).
  localparam int unsigned HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HOLD_CYCLES - 1);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [3:0] B_IDLE = 4'b1111;
`else
  localparam logic [3:0] B_IDLE = 4'b0000;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  logic [HC_W-1:0] hc;
  logic            accept;
  logic            last_hold;

  // Value to load into the b register for a given code, already in the
  // polarity b is driven with.
  function automatic logic [3:0] decode(input logic [1:0] code);
    logic [3:0] onehot;
    onehot = 4'b0001 << code;
`ifdef DEC_ACTIVE_LOW_EN
    return ~onehot;
`else
    return onehot;
`endif
  endfunction

  // hc is zero in IDLE as well, but the state term keeps the intent explicit.
  assign last_hold = (state == HOLD) && (hc == '0);
  assign a_ready   = (state == IDLE) || last_hold;
  assign accept    = a_valid && a_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hc      <= '0;
      b       <= B_IDLE;
      b_valid <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
    end else begin
      // Every hold period ends on a last_hold cycle, whether or not the next
      // code is loaded straight away, so done follows it by one clock.
      done <= last_hold;

      if (accept) begin
        state   <= HOLD;
        hc      <= HC_LOAD;
        b       <= decode(a);
        b_valid <= 1'b1;
        cnt     <= cnt + CNT_W'(1);
      end else if ((state == HOLD) && (hc != '0)) begin
        hc <= hc - HC_W'(1);
      end else begin
        // IDLE with nothing offered, or the last hold cycle with no follow-up.
        state   <= IDLE;
        hc      <= '0;
        b       <= B_IDLE;
        b_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/decoder_2x4_hold.md
Name: decoder_2x4_hold

Overview:
- Sequential 2-to-4 binary-to-one-hot decoder with a valid/ready input handshake and a programmable output hold time.
- Accepts a 2-bit code and drives the matching one-hot line on b for exactly HOLD_CYCLES clocks, then releases it.
- Sits downstream of the 4x2 one-hot-to-binary encoders and drives one-hot select or strobe lines (LED/digit enables).
- Counts accepted codes for debug.

Parameters:
- HOLD_CYCLES, 4, number of clocks each decoded one-hot value is held on b; legal range 1..255.
- CNT_W, 8, width of the accepted-code counter cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  code on a is valid.
- a  input  2  binary code to decode.
- a_ready  output  1  block can accept a code this cycle.
- b  output  4  one-hot decoded output, registered.
- b_valid  output  1  b currently holds a decoded value.
- done  output  1  one-cycle pulse after each hold period ends.
- cnt  output  CNT_W  number of accepted codes, modulo 2^CNT_W.

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: b=4'b0000, b_valid=0, done=0, cnt=0, state=IDLE, hold counter=0.
- Reset asserted mid-hold clears b and b_valid immediately, without waiting for a clock edge.
- FSM states: IDLE, HOLD.
- Hold counter hc is wide enough for HOLD_CYCLES-1.
- a_ready is combinational: 1 when state==IDLE, or when state==HOLD and hc==0 (last hold cycle). It does not depend on a_valid.
- Accept = a_valid && a_ready, sampled on the clock edge.
- On accept:
  - next cycle b = 4'b0001 << a: 0 maps to 0001, 1 to 0010, 2 to 0100, 3 to 1000.
  - b_valid=1, hc=HOLD_CYCLES-1, state=HOLD.
  - cnt increments by 1 and wraps from all-ones to 0.
- Latency: code accepted at edge N appears on b after edge N, held through edge N+HOLD_CYCLES.
- In HOLD with hc!=0: hc decrements each clock; b is stable; a_ready=0 and a is ignored.
- In HOLD with hc==0:
  - With accept: new code is loaded (back-to-back, no gap cycle), done pulses for one cycle, state stays HOLD.
  - Without accept: b=0, b_valid=0, done pulses for one cycle, state=IDLE.
- done is registered: high exactly the one cycle after the last hold cycle of each code, including back-to-back codes.
- In IDLE without accept: b=0, b_valid=0, done=0.
- HOLD_CYCLES=1: hc is always 0, so a_ready=1 continuously. A continuous a_valid stream yields a new b every cycle and done high every cycle after the first.
- All 2-bit codes are legal; there is no error output.
- Identical consecutive codes are still separate accepts: cnt counts each one and done pulses for each.

Optional Feature:
- Macro DEC_ACTIVE_LOW_EN.
- When defined:
  - b is driven active-low: reset/idle value 4'b1111; code 0 gives 1110, 1 gives 1101, 2 gives 1011, 3 gives 0111.
  - All timing, b_valid, done and cnt are unchanged.
- When undefined: active-high behaviour as above.
- The inversion is applied at the output register, not as a combinational inverter on b.

Test Plan:
- Reset: hold rst_n=0 with a_valid=1 -> b=0000, b_valid=0, done=0, cnt=0, a_ready=1. No accept occurs while reset is held.
- Single code, HOLD_CYCLES=4: a=2'd2 with a_valid pulsed one cycle -> b=0100 for exactly 4 cycles with a_ready=0 for the first 3. Then b=0000, done=1 for one cycle, cnt=1.
- Back-to-back, HOLD_CYCLES=4: a_valid held high with a=3 then a=1 -> b=1000 for 4 cycles then immediately 0010 for 4 cycles, no zero gap. done pulses twice, cnt=2.
- Ignored input: a_valid=1, a=0 presented during the middle of a hold -> b unchanged and cnt unchanged; the code is accepted only on the last hold cycle.
- Wrap and HOLD_CYCLES=1 with CNT_W=2: 5 consecutive accepts -> cnt sequence 1,2,3,0,1; a_ready constantly 1; b changes every cycle.
- Async reset mid-hold, plus DEC_ACTIVE_LOW_EN build: drop rst_n between clock edges during hold of code 1 -> b goes to 0000 (1111 in the active-low build) immediately. The active-low build also shows code 1 as 1101 and code 3 as 0111.
